coffee_dispenser: RTL and testbench
===================================

# coffee_dispenser

Timed drink-dispense sequencer that sits directly downstream of the coffee selection FSM. It consumes that FSM's one-cycle drink pulses (`exprr`, `expr_l`, `capp`) and drives the physical actuators (grinder, water pump, milk valve) through fixed-duration phases. When the sequence finishes it reports completion. While a drink is in progress it flags itself busy and rejects further requests.

## Interface
Parameters:
- `CNT_W`, 8: phase timer width; every duration parameter must be ≤ 2^CNT_W.
- `T_GRIND`, 4: grinder-on cycles, ≥ 1.
- `T_WATER_S`, 6: pump-on cycles for espresso and cappuccino, ≥ 1.
- `T_WATER_L`, 12: pump-on cycles for long espresso, ≥ 1.
- `T_MILK`, 5: milk-valve-on cycles for cappuccino, ≥ 1.

Ports:
- `clk`  in  1  single system clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `exprr`  in  1  one-cycle request: espresso.
- `expr_l`  in  1  one-cycle request: long espresso.
- `capp`  in  1  one-cycle request: cappuccino.
- `grinder`  out  1  grinder motor enable.
- `pump`  out  1  water pump enable.
- `milk_valve`  out  1  milk valve enable.
- `busy`  out  1  high from first GRIND cycle through the DONE cycle.
- `done`  out  1  one-cycle completion pulse.
- `overrun`  out  1  one-cycle pulse when a request arrives while busy.
- `drink`  out  2  latched drink code: 0 none, 1 espresso, 2 long, 3 cappuccino.
- `phase`  out  3  current state encoding, for debug.

## Operation
- States: IDLE, GRIND, WATER, MILK, DONE.
- IDLE:
  - All actuators are 0.
  - On any request, latch `drink`, load the timer with `T_GRIND-1`, and go to GRIND.
  - If more than one request is high at once, priority is `capp` > `expr_l` > `exprr`.
- GRIND: `grinder`=1. When the timer reaches 0, load `T_WATER_L-1` if drink=2, else `T_WATER_S-1`, and go to WATER.
- WATER: `pump`=1. When the timer reaches 0, go to MILK (loading `T_MILK-1`) if drink=3, else go to DONE.
- MILK: `milk_valve`=1. When the timer reaches 0, go to DONE.
- DONE:
  - `done`=1 and `busy`=1 for exactly one cycle, then go to IDLE.
  - A request on the DONE cycle is an overrun and is dropped; it is not queued.
- `overrun`:
  - Combinational: high when any request input is high and state ≠ IDLE.
  - The dropped request has no other effect; `drink` is unchanged.
- `drink` holds its value after the sequence ends and changes only on an accepted request. Reset value is 0.
- Actuators, `busy`, `done`, and `phase` are Moore outputs decoded from the state register. Actuators are mutually exclusive at all times.
- Reset:
  - Asserting `rst` at any point, including mid-phase, forces IDLE and sets timer=0 and `drink`=0.
  - All outputs are 0 during reset and in the first cycle after it.
  - A drink in progress is abandoned, with no `done` pulse.

## Timing
- A request sampled at edge n makes GRIND active from cycle n+1; there is no combinational path from request to actuator.
- Phase lengths are exactly T cycles (T=1 gives one cycle). Phase handoffs have no gap cycles.
- Total busy cycles:
  - espresso: T_GRIND+T_WATER_S+1
  - long espresso: T_GRIND+T_WATER_L+1
  - cappuccino: T_GRIND+T_WATER_S+T_MILK+1
- The earliest next accepted request is on the first IDLE cycle after DONE. The upstream FSM needs at least one cycle to re-collect credit, so no requests are lost in normal use.
- Timer arithmetic is unsigned, width CNT_W, and decrements only while nonzero. No wrap-around can occur.

## Structure
- The shared header `coffee_defs.vh` holds:
  - drink codes (`DRINK_NONE/ESP/LONG/CAP`), matching the upstream `coffee` selection values 1/2/3;
  - dispenser state encodings for `phase`;
  - the existing upstream state encodings.
- Sub-module `phase_timer`:
  - parameter CNT_W; inputs `clk`, `rst`, `load`, `val[CNT_W-1:0]`; output `zero`;
  - loadable down-counter that holds at 0.
- The top level contains the FSM, the drink latch, and output decode.

## Test plan
- Reset, then an `exprr` pulse at cycle 0 → `grinder` high cycles 1–4, `pump` 5–10, `done` at 11, `busy` high 1–11, `drink`=1, `milk_valve` never high.
- `expr_l` pulse → `pump` high for 12 cycles (5–16), `done` at 17, `drink`=2.
- `capp` pulse → `grinder` 1–4, `pump` 5–10, `milk_valve` 11–15, `done` at 16, `drink`=3.
- During a cappuccino, pulse `exprr` in the WATER phase and again on the DONE cycle → `overrun` high on both cycles, sequence timing and `drink`=3 unchanged, IDLE follows, no second sequence starts.
- `exprr` and `capp` high together in IDLE → cappuccino sequence runs and `drink`=3.
- Assert `rst` in cycle 3 of the MILK phase → all outputs 0 immediately, `drink`=0, no `done` pulse. A fresh `exprr` after reset release gives the standard espresso timing.

Source files
------------

// File: rtl/coffee_dispenser_pkg.sv
// Shared definitions for the coffee dispense sequencer: drink codes (matching the
// upstream selection values) and dispenser state encodings exposed on `phase`.
package coffee_dispenser_pkg;

    typedef enum logic [1:0] {
        DRINK_NONE = 2'd0,
        DRINK_ESP  = 2'd1,
        DRINK_LONG = 2'd2,
        DRINK_CAP  = 2'd3
    } drink_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRIND = 3'd1,
        ST_WATER = 3'd2,
        ST_MILK  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Cappuccino wins over long espresso, which wins over espresso.
    function automatic drink_e pick_drink(input logic exprr, input logic expr_l, input logic capp);
        if (capp)        return DRINK_CAP;
        else if (expr_l) return DRINK_LONG;
        else if (exprr)  return DRINK_ESP;
        else             return DRINK_NONE;
    endfunction

endpackage

// File: rtl/coffee_dispenser_phase_timer.sv
// Loadable down-counter used to time each dispense phase; it counts down to
// zero and then holds there until reloaded.
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = val;
        else if (cnt_q != '0)
            cnt_d = cnt_q - CNT_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/coffee_dispenser.sv
// Drink dispense sequencer: turns one-cycle drink requests into timed
// grinder / pump / milk-valve phases, then pulses done.
module coffee_dispenser
    import coffee_dispenser_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int T_GRIND   = 4,
    parameter int T_WATER_S = 6,
    parameter int T_WATER_L = 12,
    parameter int T_MILK    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       exprr,
    input  logic       expr_l,
    input  logic       capp,
    output logic       grinder,
    output logic       pump,
    output logic       milk_valve,
    output logic       busy,
    output logic       done,
    output logic       overrun,
    output logic [1:0] drink,
    output logic [2:0] phase
);

    localparam logic [CNT_W-1:0] LD_GRIND   = CNT_W'(T_GRIND - 1);
    localparam logic [CNT_W-1:0] LD_WATER_S = CNT_W'(T_WATER_S - 1);
    localparam logic [CNT_W-1:0] LD_WATER_L = CNT_W'(T_WATER_L - 1);
    localparam logic [CNT_W-1:0] LD_MILK    = CNT_W'(T_MILK - 1);

    state_e           state_q, state_d;
    drink_e           drink_q, drink_d;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_zero;
    logic             any_req;

    assign any_req = exprr | expr_l | capp;

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (tmr_load),
        .val  (tmr_val),
        .zero (tmr_zero)
    );

    // NOTE: every signal written here gets a default first so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        drink_d  = drink_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    drink_d  = pick_drink(exprr, expr_l, capp);
                    tmr_load = 1'b1;
                    tmr_val  = LD_GRIND;
                    state_d  = ST_GRIND;
                end
            end
            ST_GRIND: begin
                if (tmr_zero) begin
                    tmr_load = 1'b1;
                    tmr_val  = (drink_q == DRINK_LONG) ? LD_WATER_L : LD_WATER_S;
                    state_d  = ST_WATER;
                end
            end
            ST_WATER: begin
                if (tmr_zero) begin
                    if (drink_q == DRINK_CAP) begin
                        tmr_load = 1'b1;
                        tmr_val  = LD_MILK;
                        state_d  = ST_MILK;
                    end else begin
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_MILK: begin
                if (tmr_zero)
                    state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            drink_q <= DRINK_NONE;
        end else begin
            state_q <= state_d;
            drink_q <= drink_d;
        end
    end

    // Moore decode; overrun is the only output that looks at the request inputs.
    assign grinder    = (state_q == ST_GRIND);
    assign pump       = (state_q == ST_WATER);
    assign milk_valve = (state_q == ST_MILK);
    assign done       = (state_q == ST_DONE);
    assign busy       = (state_q != ST_IDLE);
    assign overrun    = any_req && (state_q != ST_IDLE);
    assign drink      = drink_q;
    assign phase      = state_q;

endmodule

// File: tb/tb_coffee_dispenser.sv
// Self-checking bench for coffee_dispenser: table of drink requests plus hand
// sequences for overrun and mid-phase reset, checked cycle by cycle via a queue.
module tb_coffee_dispenser;

    localparam int CNT_W = 8;
    localparam int TG    = 4;
    localparam int TWS   = 6;
    localparam int TWL   = 12;
    localparam int TM    = 5;

    typedef struct packed {
        logic       grinder;
        logic       pump;
        logic       milk;
        logic       busy;
        logic       done;
        logic       overrun;
        logic [1:0] drink;
        logic [2:0] phase;
    } out_t;

    typedef struct {
        logic       e;
        logic       l;
        logic       c;
        logic [1:0] d;
        string      name;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic exprr = 1'b0, expr_l = 1'b0, capp = 1'b0;
    logic grinder, pump, milk_valve, busy, done, overrun;
    logic [1:0] drink;
    logic [2:0] phase;

    int   n_checks = 0;
    int   n_pass   = 0;
    out_t exp_q[$];
    logic [1:0] cur_drink = 2'd0;

    always #5 clk = ~clk;

    coffee_dispenser #(
        .CNT_W(CNT_W), .T_GRIND(TG), .T_WATER_S(TWS), .T_WATER_L(TWL), .T_MILK(TM)
    ) dut (
        .clk(clk), .rst(rst), .exprr(exprr), .expr_l(expr_l), .capp(capp),
        .grinder(grinder), .pump(pump), .milk_valve(milk_valve), .busy(busy),
        .done(done), .overrun(overrun), .drink(drink), .phase(phase)
    );

    function automatic out_t actual();
        out_t a;
        a = {grinder, pump, milk_valve, busy, done, overrun, drink, phase};
        return a;
    endfunction

    // Expected outputs k cycles after a request of drink d, from the phase windows.
    function automatic out_t model(input logic [1:0] d, input logic [1:0] prev,
                                   input int k, input logic req);
        out_t o;
        int tw, tm, b;
        o  = '0;
        tw = (d == 2'd2) ? TWL : TWS;
        tm = (d == 2'd3) ? TM : 0;
        b  = TG + tw + tm + 1;
        o.drink = (k == 0) ? prev : d;
        if (k >= 1 && k <= TG) begin
            o.grinder = 1'b1; o.phase = 3'd1;
        end else if (k > TG && k <= TG + tw) begin
            o.pump = 1'b1; o.phase = 3'd2;
        end else if (k > TG + tw && k <= TG + tw + tm) begin
            o.milk = 1'b1; o.phase = 3'd3;
        end else if (k == b) begin
            o.done = 1'b1; o.phase = 3'd4;
        end
        o.busy    = (k >= 1 && k <= b);
        o.overrun = req && o.busy;
        return o;
    endfunction

    task automatic check(input string name);
        out_t e, a;
        a = actual();
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL %s: scoreboard empty, actual=%h", name, a);
            return;
        end
        e = exp_q.pop_front();
        n_checks++;
        if (a === e) n_pass++;
        else $display("FAIL %s: actual=%h required=%h (g p m busy done ovr drink phase)", name, a, e);
    endtask

    // Drive one cycle's inputs just after the edge, push its expectation, sample at negedge.
    task automatic cycle(input logic e, input logic l, input logic c, input out_t x, input string name);
        @(posedge clk);
        #1;
        exprr = e; expr_l = l; capp = c;
        exp_q.push_back(x);
        @(negedge clk);
        check(name);
    endtask

    // Run a full sequence; extra exprr pulses at cycles ov1/ov2 (-1 = none).
    task automatic run_seq(input vec_t v, input int ov1, input int ov2);
        int tw, tm, b;
        logic r;
        tw = (v.d == 2'd2) ? TWL : TWS;
        tm = (v.d == 2'd3) ? TM : 0;
        b  = TG + tw + tm + 1;
        cycle(v.e, v.l, v.c, model(v.d, cur_drink, 0, 1'b1), {v.name, "_req"});
        for (int k = 1; k <= b + 2; k++) begin
            r = (k == ov1) || (k == ov2);
            cycle(r, 1'b0, 1'b0, model(v.d, cur_drink, k, r), $sformatf("%s_k%0d", v.name, k));
        end
        cur_drink = v.d;
    endtask

    initial begin
        vec_t vecs[6];
        vec_t v;
        out_t zero_o;
        zero_o = '0;
        vecs[0] = '{e:1'b1, l:1'b0, c:1'b0, d:2'd1, name:"espresso"};
        vecs[1] = '{e:1'b0, l:1'b1, c:1'b0, d:2'd2, name:"long"};
        vecs[2] = '{e:1'b0, l:1'b0, c:1'b1, d:2'd3, name:"capp"};
        vecs[3] = '{e:1'b1, l:1'b0, c:1'b1, d:2'd3, name:"esp_capp"};
        vecs[4] = '{e:1'b1, l:1'b1, c:1'b0, d:2'd2, name:"esp_long"};
        vecs[5] = '{e:1'b1, l:1'b1, c:1'b1, d:2'd3, name:"all3"};

        // Reset state, during reset and the first cycle after release.
        #2;
        exp_q.push_back(zero_o);
        check("in_reset");
        @(posedge clk); #1; rst = 1'b0;
        exp_q.push_back(zero_o);
        @(negedge clk);
        check("post_reset");

        for (int i = 0; i < 6; i++)
            run_seq(vecs[i], -1, -1);

        // Overrun in WATER (k=7) and on the DONE cycle (k=16) of a cappuccino.
        v = '{e:1'b0, l:1'b0, c:1'b1, d:2'd3, name:"capp_ovr"};
        run_seq(v, 7, TG + TWS + TM + 1);

        // Reset asserted in the third MILK cycle of a cappuccino.
        cycle(1'b0, 1'b0, 1'b1, model(2'd3, cur_drink, 0, 1'b1), "rst_seq_req");
        for (int k = 1; k <= TG + TWS + 2; k++)
            cycle(1'b0, 1'b0, 1'b0, model(2'd3, cur_drink, k, 1'b0), $sformatf("rst_seq_k%0d", k));
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        exp_q.push_back(zero_o);
        check("rst_async");
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(zero_o);
            @(negedge clk);
            check($sformatf("rst_hold%0d", k));
        end
        @(posedge clk); #1; rst = 1'b0;
        exp_q.push_back(zero_o);
        @(negedge clk);
        check("rst_release");
        cur_drink = 2'd0;
        run_seq(vecs[0], -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, %0d checks done", n_checks);
        $fatal(1, "timeout");
    end

endmodule
